quire_to_posit_4_0: RTL and testbench
=====================================

# quire_to_posit_4_0

Converts the 19-bit two's-complement quire stream from the posit<4,0> accumulator back into 4-bit posit<4,0> encodings. Uses round-to-nearest-even in the posit bit pattern, saturates to maxpos, and never underflows a nonzero value to zero. Sits directly downstream of the quire accumulator master port and uses the same rts/rtr/sow/eow stream protocol on both sides.

## Interface
- ONLY_EOW, 0: if 1, only input words with eow_i=1 produce an output word; other accepted words are consumed and dropped.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rts_i  in  1  upstream word valid
- rtr_o  out  1  ready to receive (registered)
- sow_i  in  1  start of window tag
- eow_i  in  1  end of window tag
- data_i  in  19  quire, two's complement; value = data_i / 16
- NaR_i  in  1  quire is NaR
- sign_i  in  1  unused (sign is taken from data_i[18]); kept for port compatibility
- zero_i  in  1  unused; kept for port compatibility
- rtr_i  in  1  downstream ready
- rts_o  out  1  output word valid
- sow_o  out  1  sow tag of the output word
- eow_o  out  1  eow tag of the output word
- posit_o  out  4  posit<4,0> encoding
- NaR_o  out  1  posit_o == 4'b1000
- zero_o  out  1  posit_o == 4'b0000
- sign_o  out  1  posit_o[3]

## Operation
- Reset: rst_n is synchronous and active-low; clock is clk. All outputs are 0 while in reset; the skid buffer and all stage valids are cleared.
- process_en = rtr_i | ~rts_o. All pipeline stages advance only when process_en=1.
- Input transfer occurs when rts_i & rtr_o.
- Skid buffer (1 entry): a word transferred while process_en=0 is captured into the skid buffer. rtr_o(n+1) = process_en(n) & ~skid_full(n+1). When process_en returns, the skid buffer drains into stage 1 before any new input. Words are never lost, duplicated or reordered.
- Stage 1 registers:
  - magnitude M = |data_i|, 19-bit unsigned; -2^18 gives M = 2^18.
  - neg = data_i[18], NaR, sow, eow.
  - keep = ~ONLY_EOW | eow_i. Words with keep=0 enter with valid=0.
- Stage 2 maps M to a 3-bit code k (units of 1/16):
  - M=0 → 0
  - 1..5 → 1
  - 6..10 → 2
  - 11..13 → 3
  - 14..20 → 4
  - 21..27 → 5
  - 28..48 → 6
  - ≥49 → 7
- Stage 3 encodes the output:
  - posit = NaR ? 4'b1000 : (neg ? (-{1'b0,k}) mod 16 : {1'b0,k}).
  - NaR_o, zero_o and sign_o are derived from the registered posit.
- Ties in the mapping go to the even pattern: 6→0010, 10→0010, 14→0100, 20→0100, 28→0110, 48→0110.

## Timing
- Latency: 3 clk cycles from input transfer to rts_o when not stalled. Throughput: 1 word per cycle.
- While rts_o & ~rtr_i: posit_o, the tags and all flags are held stable, and rts_o stays 1.
- rtr_o falls 1 cycle after a stall begins. At most one word is accepted during that cycle, into the skid buffer.
- With ONLY_EOW=1, a run of non-eow inputs produces no rts_o pulses. rtr_o is unaffected by dropped words.
- Simultaneous skid drain and new input: the skid word enters stage 1. The new word can only transfer once rtr_o is 1 again, which is never in that same cycle.
- Reset mid-stream: all in-flight and skid words are discarded. rts_o=0 and rtr_o=0 during reset; rtr_o rises in the first cycle after reset deasserts.

## Test plan
- Exact values, ONLY_EOW=0, rtr_i=1:
  - data_i 0x00010 → posit_o 0100.
  - data_i 0x7FFE8 (-24) → 1011, sign_o=1.
  - data_i 0 → 0000, zero_o=1.
  - NaR_i=1, data_i 0x00010 → 1000, NaR_o=1.
  - Each result appears 3 cycles after its input transfer.
- Rounding boundaries: data_i 1, 5, 6, 10, 11, 13, 14, 20, 21, 27, 28, 48, 49 → 0001, 0001, 0010, 0010, 0011, 0011, 0100, 0100, 0101, 0101, 0110, 0110, 0111.
- Extremes: data_i 0x3FFFF → 0111; data_i 0x40000 (-2^18) → 1001.
- Backpressure: stream 8 words with rts_i=1 while toggling rtr_i (0 for 3 cycles, then 1) → all 8 outputs appear in order with correct values and tags; outputs are held stable while rtr_i=0.
- ONLY_EOW=1: window of 5 words, sow on word 0 and eow on word 4 with data_i 0x00030 → exactly one output, posit_o 0110, eow_o=1, sow_o=0.
- Assert rst_n=0 for 1 cycle with 2 words in flight → rts_o=0 the next cycle and no stale word ever emerges; the next word converts normally.

Source files
------------

// File: rtl/quire_to_posit_4_0.sv
// Quire (19-bit two's complement, LSB = 1/16) to posit<4,0> converter.
// Three-stage stream pipeline with a one-entry skid buffer on the input side.
module quire_to_posit_4_0 #(
  parameter bit ONLY_EOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rts_i,
  output logic        rtr_o,
  input  logic        sow_i,
  input  logic        eow_i,
  input  logic [18:0] data_i,
  input  logic        NaR_i,
  input  logic        sign_i,
  input  logic        zero_i,
  input  logic        rtr_i,
  output logic        rts_o,
  output logic        sow_o,
  output logic        eow_o,
  output logic [3:0]  posit_o,
  output logic        NaR_o,
  output logic        zero_o,
  output logic        sign_o
);

  logic unused_ok;
  assign unused_ok = ^{sign_i, zero_i};

  logic process_en;
  logic xfer;
  assign process_en = rtr_i | ~rts_o;
  assign xfer       = rts_i & rtr_o;

  logic        skid_full;
  logic        skid_full_next;
  logic [18:0] skid_data;
  logic        skid_nar;
  logic        skid_sow;
  logic        skid_eow;

  logic        src_valid;
  logic [18:0] src_data;
  logic        src_nar;
  logic        src_sow;
  logic        src_eow;
  logic [18:0] src_mag;

  // A parked skid word always goes ahead of anything new from upstream.
  always_comb begin
    src_valid = xfer;
    src_data  = data_i;
    src_nar   = NaR_i;
    src_sow   = sow_i;
    src_eow   = eow_i;
    if (skid_full) begin
      src_valid = 1'b1;
      src_data  = skid_data;
      src_nar   = skid_nar;
      src_sow   = skid_sow;
      src_eow   = skid_eow;
    end
  end

  assign src_mag = src_data[18] ? (~src_data + 19'd1) : src_data;

  always_comb begin
    skid_full_next = skid_full;
    if (process_en)
      skid_full_next = 1'b0;
    else if (xfer)
      skid_full_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_nar  <= 1'b0;
      skid_sow  <= 1'b0;
      skid_eow  <= 1'b0;
      rtr_o     <= 1'b0;
    end else begin
      skid_full <= skid_full_next;
      if (!process_en && xfer) begin
        skid_data <= data_i;
        skid_nar  <= NaR_i;
        skid_sow  <= sow_i;
        skid_eow  <= eow_i;
      end
      rtr_o <= process_en & ~skid_full_next;
    end
  end

  // Stage 1: magnitude and tags
  logic        s1_valid;
  logic [18:0] s1_mag;
  logic        s1_neg;
  logic        s1_nar;
  logic        s1_sow;
  logic        s1_eow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_neg   <= 1'b0;
      s1_nar   <= 1'b0;
      s1_sow   <= 1'b0;
      s1_eow   <= 1'b0;
    end else if (process_en) begin
      s1_valid <= src_valid & (~ONLY_EOW | src_eow);
      s1_mag   <= src_mag;
      s1_neg   <= src_data[18];
      s1_nar   <= src_nar;
      s1_sow   <= src_sow;
      s1_eow   <= src_eow;
    end
  end

  // Stage 2: thresholds are the round-to-nearest-even midpoints between posits,
  // with 1..5 clamped to minpos and everything from 49 up saturating to maxpos.
  logic [2:0] k_next;
  always_comb begin
    if (s1_mag == 19'd0)       k_next = 3'd0;
    else if (s1_mag <= 19'd5)  k_next = 3'd1;
    else if (s1_mag <= 19'd10) k_next = 3'd2;
    else if (s1_mag <= 19'd13) k_next = 3'd3;
    else if (s1_mag <= 19'd20) k_next = 3'd4;
    else if (s1_mag <= 19'd27) k_next = 3'd5;
    else if (s1_mag <= 19'd48) k_next = 3'd6;
    else                       k_next = 3'd7;
  end

  logic       s2_valid;
  logic [2:0] s2_k;
  logic       s2_neg;
  logic       s2_nar;
  logic       s2_sow;
  logic       s2_eow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_k     <= '0;
      s2_neg   <= 1'b0;
      s2_nar   <= 1'b0;
      s2_sow   <= 1'b0;
      s2_eow   <= 1'b0;
    end else if (process_en) begin
      s2_valid <= s1_valid;
      s2_k     <= k_next;
      s2_neg   <= s1_neg;
      s2_nar   <= s1_nar;
      s2_sow   <= s1_sow;
      s2_eow   <= s1_eow;
    end
  end

  // Stage 3: negative posits are the two's complement of the positive pattern
  logic [3:0] posit_next;
  assign posit_next = s2_nar ? 4'b1000 : (s2_neg ? (4'd0 - {1'b0, s2_k}) : {1'b0, s2_k});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rts_o   <= 1'b0;
      sow_o   <= 1'b0;
      eow_o   <= 1'b0;
      posit_o <= '0;
    end else if (process_en) begin
      rts_o   <= s2_valid;
      sow_o   <= s2_sow;
      eow_o   <= s2_eow;
      posit_o <= posit_next;
    end
  end

  assign NaR_o  = (posit_o == 4'b1000);
  assign zero_o = (posit_o == 4'b0000);
  assign sign_o = posit_o[3];

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Randomized and directed bench for quire_to_posit_4_0; a nearest-posit
// reference model feeds per-DUT scoreboards (ONLY_EOW=0 and ONLY_EOW=1).
module tb_quire_to_posit_4_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, nar_i = 1'b0, rtr_i = 1'b1;
  logic [18:0] data_i = '0;
  logic        rtr_o, rts_o, sow_o, eow_o, nar_o, zero_o, sign_o;
  logic [3:0]  posit_o;

  logic        rts1 = 1'b0, sow1 = 1'b0, eow1 = 1'b0;
  logic [18:0] data1 = '0;
  logic        rtr_o1, rts_o1, sow_o1, eow_o1, nar_o1, zero_o1, sign_o1;
  logic [3:0]  posit_o1;

  quire_to_posit_4_0 #(.ONLY_EOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .NaR_i(nar_i), .sign_i(data_i[18]), .zero_i(data_i == 19'd0),
    .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .posit_o(posit_o),
    .NaR_o(nar_o), .zero_o(zero_o), .sign_o(sign_o)
  );

  quire_to_posit_4_0 #(.ONLY_EOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rts_i(rts1), .rtr_o(rtr_o1), .sow_i(sow1), .eow_i(eow1),
    .data_i(data1), .NaR_i(1'b0), .sign_i(data1[18]), .zero_i(data1 == 19'd0),
    .rtr_i(1'b1), .rts_o(rts_o1), .sow_o(sow_o1), .eow_o(eow_o1), .posit_o(posit_o1),
    .NaR_o(nar_o1), .zero_o(zero_o1), .sign_o(sign_o1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Posit<4,0> values 0, 1/4, 1/2, 3/4, 1, 3/2, 2, 4 in units of 1/16.
  localparam int PV[8] = '{0, 4, 8, 12, 16, 24, 32, 64};

  function automatic logic [3:0] ref_posit(input logic [18:0] d, input logic nar);
    int v, m, k, lo;
    if (nar) return 4'b1000;
    v  = int'($signed(d));
    m  = (v < 0) ? -v : v;
    lo = 1;
    if (m == 0)       k = 0;
    else if (m <= 4)  k = 1;
    else if (m >= 64) k = 7;
    else begin
      for (int j = 1; j < 7; j++)
        if (m >= PV[j] && m < PV[j+1]) lo = j;
      if (2*m < PV[lo] + PV[lo+1])      k = lo;
      else if (2*m > PV[lo] + PV[lo+1]) k = lo + 1;
      else                              k = (lo % 2 == 0) ? lo : lo + 1;
    end
    return (v < 0) ? 4'((16 - k) % 16) : 4'(k);
  endfunction

  typedef struct {
    logic [3:0] p;
    logic       sow;
    logic       eow;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, ne;
  int   cyc = 0;
  int   out1 = 0;
  logic lat_chk = 1'b0;
  logic chk_rst = 1'b0, chk_rise = 1'b0;
  logic hold0 = 1'b0;
  logic [3:0] hp;
  logic [4:0] htags;

  // Sampled on the falling edge: these values decide the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      hold0   = 1'b0;
      chk_rst = 1'b1;
    end else begin
      if (chk_rise) begin
        check("rtr_rise", rtr_o, 1);
        chk_rise = 1'b0;
      end
      if (chk_rst) begin
        check("rst_rts", rts_o, 0);
        check("rst_rtr", rtr_o, 0);
        check("rst_posit", posit_o, 0);
        chk_rst  = 1'b0;
        chk_rise = 1'b1;
      end
      if (hold0) begin
        check("hold_rts", rts_o, 1);
        check("hold_posit", posit_o, hp);
        check("hold_tags", {sow_o, eow_o, nar_o, zero_o, sign_o}, htags);
      end
      hold0 = rts_o & ~rtr_i;
      hp    = posit_o;
      htags = {sow_o, eow_o, nar_o, zero_o, sign_o};

      if (rts_o && rtr_i) begin
        $display("[TB] out0 posit=%b sow=%0d eow=%0d cyc=%0d", posit_o, sow_o, eow_o, cyc);
        if (q0.size() == 0) check("unexpected0", 1, 0);
        else begin
          e0 = q0.pop_front();
          check("posit0", posit_o, e0.p);
          check("tags0", {sow_o, eow_o}, {e0.sow, e0.eow});
          check("flags0", {nar_o, zero_o, sign_o}, {e0.p == 4'b1000, e0.p == 4'b0000, e0.p[3]});
          if (lat_chk) check("latency", cyc - e0.cyc, 3);
        end
      end
      if (rts_i && rtr_o) begin
        ne.p = ref_posit(data_i, nar_i); ne.sow = sow_i; ne.eow = eow_i; ne.cyc = cyc;
        q0.push_back(ne);
      end

      if (rts_o1) begin
        out1++;
        $display("[TB] out1 posit=%b sow=%0d eow=%0d cyc=%0d", posit_o1, sow_o1, eow_o1, cyc);
        if (q1.size() == 0) check("unexpected1", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("posit1", posit_o1, e1.p);
          check("tags1", {sow_o1, eow_o1}, {e1.sow, e1.eow});
          check("flags1", {nar_o1, zero_o1, sign_o1}, {e1.p == 4'b1000, e1.p == 4'b0000, e1.p[3]});
        end
      end
      if (rts1 && rtr_o1 && eow1) begin
        ne.p = ref_posit(data1, 1'b0); ne.sow = sow1; ne.eow = 1'b1; ne.cyc = cyc;
        q1.push_back(ne);
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [18:0] d, input logic nar, input logic s, input logic e);
    int   n = 0;
    logic acc;
    rts_i = 1'b1; data_i = d; nar_i = nar; sow_i = s; eow_i = e;
    do begin
      @(negedge clk);
      acc = rtr_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; nar_i = 1'b0;
    check("send_acc", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    rtr_i = 1'b1; rts_i = 1'b0; rts1 = 1'b0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    tick(2);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
  endtask

  function automatic logic [18:0] rand_data();
    int m;
    if ($urandom_range(0, 3) == 0) return 19'($urandom);
    m = $urandom_range(0, 80);
    return ($urandom_range(0, 1) == 1) ? 19'(-m) : 19'(m);
  endfunction

  int bnd[13] = '{1, 5, 6, 10, 11, 13, 14, 20, 21, 27, 28, 48, 49};
  int base1;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Exact values, boundaries and extremes back to back with latency checks
    lat_chk = 1'b1;
    send(19'h00010, 1'b0, 1'b1, 1'b0);
    send(19'h7FFE8, 1'b0, 1'b0, 1'b0);
    send(19'h00000, 1'b0, 1'b0, 1'b0);
    send(19'h00010, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) send(19'(bnd[i]), 1'b0, 1'b0, 1'b0);
    send(19'h3FFFF, 1'b0, 1'b0, 1'b0);
    send(19'h40000, 1'b0, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 8 words while rtr_i toggles
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_data(), 1'b0, i == 0, i == 7);
      end
      begin
        tick(2); rtr_i = 1'b0; tick(3); rtr_i = 1'b1; tick(3);
        rtr_i = 1'b0; tick(3); rtr_i = 1'b1;
      end
    join
    drain();

    // ONLY_EOW window: exactly one output expected
    base1 = out1;
    for (int i = 0; i < 5; i++) begin
      rts1 = 1'b1; sow1 = (i == 0); eow1 = (i == 4);
      data1 = (i == 4) ? 19'h00030 : rand_data();
      tick(1);
    end
    rts1 = 1'b0; sow1 = 1'b0; eow1 = 1'b0;
    drain();
    check("only_eow_count", out1 - base1, 1);

    // Reset with two words in flight
    send(19'h00020, 1'b0, 1'b0, 1'b0);
    send(19'h7FFF0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    send(19'h00018, 1'b0, 1'b1, 1'b1);
    drain();

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      rts_i  = ($urandom_range(0, 3) != 0);
      data_i = rand_data();
      nar_i  = ($urandom_range(0, 15) == 0);
      sow_i  = ($urandom_range(0, 7) == 0);
      eow_i  = ($urandom_range(0, 7) == 0);
      rtr_i  = ($urandom_range(0, 9) < 7);
      rts1   = ($urandom_range(0, 1) == 1);
      data1  = rand_data();
      sow1   = ($urandom_range(0, 3) == 0);
      eow1   = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    rts_i = 1'b0; nar_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0;
    rts1 = 1'b0; sow1 = 1'b0; eow1 = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
